// File: rtl/wr_ptr_full_gen.sv
// Write-side pointer, memory write strobe and full/level/overflow flags for an async FIFO.
// Flags are computed against the read pointer already synchronized into wr_clk.
module wr_ptr_full_gen #(
   parameter int Addr_Width         = 8,
   parameter int Almost_Full_Thresh = 4
) (
   input  logic                  wr_clk,
   input  logic                  wr_rstn,
   input  logic                  wr_en,
   input  logic [Addr_Width:0]   rd_ptr_sync,
   input  logic                  ovf_clr,
   output logic [Addr_Width:0]   wr_ptr,
   output logic [Addr_Width-1:0] wr_addr,
   output logic                  mem_wr_en,
   output logic                  full,
   output logic                  almost_full,
   output logic [Addr_Width:0]   wr_level,
   output logic                  overflow
);

   localparam int AW    = Addr_Width;
   localparam int Depth = 2 ** AW;
   localparam logic [AW:0] AF_LEVEL = (AW + 1)'(Depth - Almost_Full_Thresh);

   logic [AW:0] wr_bin;
   logic [AW:0] wr_bin_next;
   logic [AW:0] wr_gray_next;
   logic [AW:0] rd_bin;
   logic [AW:0] wr_level_next;
   logic        full_next;
   logic        almost_full_next;
   logic        push;

   // Handshake: wr_en is the valid, ~full the ready; a push is transferred on
   // a wr_clk edge only when both are high, and the memory samples on that edge.
   assign push      = wr_en & ~full & wr_rstn;
   assign mem_wr_en = push;
   assign wr_addr   = wr_bin[AW-1:0];

   assign wr_bin_next  = wr_bin + {{AW{1'b0}}, push};
   assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

   always_comb begin
      rd_bin     = '0;
      rd_bin[AW] = rd_ptr_sync[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         rd_bin[i] = rd_bin[i+1] ^ rd_ptr_sync[i];
      end
   end

   // Full when the next write pointer is exactly one lap ahead of the read pointer.
   assign full_next        = (wr_gray_next == {~rd_ptr_sync[AW:AW-1], rd_ptr_sync[AW-2:0]});
   assign wr_level_next    = wr_bin_next - rd_bin;
   assign almost_full_next = (wr_level_next >= AF_LEVEL);

   always_ff @(posedge wr_clk or negedge wr_rstn) begin
      if (!wr_rstn) begin
         wr_bin      <= '0;
         wr_ptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
      end else begin
         wr_bin      <= wr_bin_next;
         wr_ptr      <= wr_gray_next;
         full        <= full_next;
         almost_full <= almost_full_next;
         wr_level    <= wr_level_next;
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wr_ptr_full_gen.sv
// Randomized self-checking bench for wr_ptr_full_gen (Addr_Width=8, Almost_Full_Thresh=4).
// Reference model tracks push and read counts as integers and derives flags from occupancy.
module tb_wr_ptr_full_gen;

   logic       wr_clk = 1'b0;
   logic       wr_rstn = 1'b0;
   logic       wr_en = 1'b0;
   logic [8:0] rd_ptr_sync = '0;
   logic       ovf_clr = 1'b0;
   logic [8:0] wr_ptr;
   logic [7:0] wr_addr;
   logic       mem_wr_en;
   logic       full;
   logic       almost_full;
   logic [8:0] wr_level;
   logic       overflow;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   int   m_wr = 0;
   int   m_level = 0;
   logic m_full = 1'b0;
   logic m_af = 1'b0;
   logic m_ovf = 1'b0;
   logic [7:0] exp_q[$];

   wr_ptr_full_gen #(.Addr_Width(8), .Almost_Full_Thresh(4)) dut (
      .wr_clk(wr_clk), .wr_rstn(wr_rstn), .wr_en(wr_en), .rd_ptr_sync(rd_ptr_sync),
      .ovf_clr(ovf_clr), .wr_ptr(wr_ptr), .wr_addr(wr_addr), .mem_wr_en(mem_wr_en),
      .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
   );

   always #5 wr_clk = ~wr_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [8:0] gray(input int n);
      logic [8:0] b;
      b = n[8:0];
      return b ^ (b >> 1);
   endfunction

   function automatic int mod512(input int n);
      return ((n % 512) + 512) % 512;
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ptr"}, wr_ptr, 0);
      check_eq({tag, "_full"}, full, 0);
      check_eq({tag, "_af"}, almost_full, 0);
      check_eq({tag, "_level"}, wr_level, 0);
      check_eq({tag, "_ovf"}, overflow, 0);
      check_eq({tag, "_wen"}, mem_wr_en, 0);
      check_eq({tag, "_addr"}, wr_addr, 0);
   endtask

   task automatic model_reset();
      m_wr = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
      exp_q.delete();
   endtask

   // One wr_clk cycle: drive at negedge, check strobe, then check registered outputs after posedge.
   task automatic do_cycle(input logic en, input logic clr, input int rd_cnt);
      logic       exp_push;
      logic [8:0] prev_ptr;
      @(negedge wr_clk);
      wr_en = en;
      ovf_clr = clr;
      rd_ptr_sync = gray(rd_cnt);
      #1;
      exp_push = en && !m_full;
      if (exp_push) exp_q.push_back(8'(m_wr % 256));
      check_eq("mem_wr_en", mem_wr_en, exp_push);
      if (mem_wr_en) begin
         if (exp_q.size() == 0) check_eq("addr_unexpected", 1, 0);
         else check_eq("wr_addr", wr_addr, exp_q.pop_front());
      end
      prev_ptr = wr_ptr;
      @(posedge wr_clk);
      #1;
      m_ovf = (en && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      if (exp_push) m_wr = mod512(m_wr + 1);
      m_level = mod512(m_wr - rd_cnt);
      m_full = (m_level == 256);
      m_af = (m_level >= 252);
      check_eq("wr_ptr", wr_ptr, gray(m_wr));
      check_eq("wr_level", wr_level, m_level);
      check_eq("full", full, m_full);
      check_eq("almost_full", almost_full, m_af);
      check_eq("overflow", overflow, m_ovf);
      if (exp_push) check_eq("gray_1bit", $countones(prev_ptr ^ wr_ptr), 1);
      else check_eq("ptr_hold", wr_ptr, prev_ptr);
   endtask

   initial begin
      int acc;
      int guard;
      int rd;
      logic en;

      // Reset held with a push request pending
      wr_rstn = 0; wr_en = 1;
      #2;
      check_all_zero("rst");
      @(posedge wr_clk); #1;
      check_all_zero("rst_hold");
      @(negedge wr_clk);
      wr_en = 0;
      wr_rstn = 1;
      model_reset();

      // Fill with read side idle
      for (int i = 1; i <= 256; i++) begin
         do_cycle(1'b1, 1'b0, 0);
         if (i == 1) check_eq("first_ptr", wr_ptr, 9'h001);
         if (i == 251) check_eq("af_251", almost_full, 0);
         if (i == 252) begin
            check_eq("af_252", almost_full, 1);
            check_eq("lvl_252", wr_level, 252);
         end
         if (i == 255) check_eq("full_255", full, 0);
      end
      check_eq("full_256", full, 1);
      check_eq("lvl_256", wr_level, 256);
      check_eq("ptr_256", wr_ptr, 9'h180);

      // Overflow while full
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b1, 1'b0, 0);
         check_eq("ovf_ptr", wr_ptr, 9'h180);
         check_eq("ovf_set", overflow, 1);
      end
      do_cycle(1'b0, 1'b1, 0);
      check_eq("ovf_clr", overflow, 0);
      do_cycle(1'b1, 1'b1, 0);
      check_eq("ovf_set_wins", overflow, 1);
      do_cycle(1'b0, 1'b0, 0);
      check_eq("ovf_sticky", overflow, 1);
      do_cycle(1'b0, 1'b1, 0);

      // Drain one entry
      do_cycle(1'b0, 1'b0, 1);
      check_eq("drain_full", full, 0);
      check_eq("drain_lvl", wr_level, 255);
      check_eq("drain_af", almost_full, 1);
      do_cycle(1'b1, 1'b0, 1);
      check_eq("refill_full", full, 1);

      // Read side trails the write pointer by 10 across several wraps
      acc = 0; guard = 0;
      while (acc < 600 && guard < 4000) begin
         en = ($urandom_range(0, 3) != 0);
         rd = m_wr + ((en && !m_full) ? 1 : 0) - 10;
         if (en && !m_full) acc++;
         do_cycle(en, 1'b0, mod512(rd));
         if (acc > 2) check_eq("wrap_lvl", wr_level, 10);
         guard++;
      end
      check_eq("wrap_done", acc, 600);

      // Asynchronous reset between edges at level 100
      @(negedge wr_clk);
      wr_rstn = 0; wr_en = 0;
      #1;
      @(negedge wr_clk);
      wr_rstn = 1;
      model_reset();
      for (int i = 0; i < 100; i++) do_cycle(($urandom_range(0, 1) == 1) || (i < 100), 1'b0, 0);
      check_eq("lvl_100", wr_level, 100);
      @(negedge wr_clk);
      #2;
      wr_en = 1;
      wr_rstn = 0;
      #1;
      check_all_zero("async_rst");
      @(posedge wr_clk); #1;
      check_all_zero("async_rst_hold");
      @(negedge wr_clk);
      wr_en = 0;
      wr_rstn = 1;
      model_reset();
      do_cycle(1'b1, 1'b0, 0);
      check_eq("post_rst_ptr", wr_ptr, 9'h001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wr_ptr_full_gen.md
Name: wr_ptr_full_gen

Overview:
- Write-side pointer and full-flag generator for the asynchronous FIFO; the write-domain counterpart to the write-to-read pointer synchronizer.
- Accepts push requests in the wr_clk domain and drives the memory write address and enable.
- Produces the registered Gray-coded write pointer that is carried into the read domain.
- Compares its own pointer against the read pointer already synchronized into wr_clk to produce full, almost_full, fill level and an overflow error.

Parameters:
- Addr_Width, 8, memory address width; FIFO depth DEPTH = 2**Addr_Width; legal range Addr_Width >= 2.
- Almost_Full_Thresh, 4, almost_full asserts when free slots <= this value; legal range 1..DEPTH-1.

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rstn  input  1  asynchronous active-low reset.
- wr_en  input  1  push request; a push is accepted only when full=0.
- rd_ptr_sync  input  Addr_Width+1  Gray-coded read pointer, already double-flopped into wr_clk.
- ovf_clr  input  1  clears the sticky overflow flag.
- wr_ptr  output  Addr_Width+1  registered Gray write pointer, fed to the read-domain synchronizer.
- wr_addr  output  Addr_Width  memory write address (low bits of the binary pointer).
- mem_wr_en  output  1  memory write strobe.
- full  output  1  FIFO full, registered.
- almost_full  output  1  free slots <= Almost_Full_Thresh, registered.
- wr_level  output  Addr_Width+1  write-side occupancy, registered, range 0..DEPTH.
- overflow  output  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset, asynchronous on the wr_rstn falling edge and held while low:
  - binary pointer, wr_ptr, full, almost_full, wr_level and overflow all return to 0.
  - mem_wr_en is forced to 0 while wr_rstn=0.
- Accept rule: push = wr_en & ~full.
  - mem_wr_en = push (combinational).
  - wr_addr = wr_bin[Addr_Width-1:0] (registered pointer, no added latency).
  - The memory samples data on the same edge that the pointer advances.
- Pointer update:
  - wr_bin_next = wr_bin + push, modulo 2**(Addr_Width+1).
  - wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1).
  - Both are registered; wr_ptr is the Gray register itself (a glitch-free flop output; no logic between the flop and the port).
- Read pointer decode:
  - rd_bin = Gray-to-binary of rd_ptr_sync (bit i = XOR of bits Addr_Width..i).
  - Decoded every cycle, whether or not a push occurs.
- Full:
  - full_next = (wr_gray_next == {~rd_ptr_sync[AW:AW-1], rd_ptr_sync[AW-2:0]}).
  - Registered, so full is asserted on the clock edge that accepts the DEPTH-th outstanding push. No push is ever accepted into a full FIFO.
- Level and almost_full:
  - wr_level_next = wr_bin_next - rd_bin, modulo 2**(Addr_Width+1).
  - almost_full_next = (wr_level_next >= DEPTH - Almost_Full_Thresh).
  - Both are registered.
- Pessimism: full, almost_full and wr_level lag reads by the synchronizer latency. They are conservative by design and recompute every cycle as rd_ptr_sync advances, even with wr_en=0.
- Overflow:
  - Set on any cycle with wr_en=1 and full=1.
  - Cleared by ovf_clr=1; if set and clear coincide, set wins.
  - The ignored push leaves the pointer and memory unchanged.
- Wrap-around: the binary pointer wraps from 2**(Addr_Width+1)-1 to 0. The extra MSB distinguishes full from empty across the wrap, so no special case is needed.
- Reset mid-operation: the pointer returns to 0 immediately. Keeping the read side consistent is the system reset's responsibility; no cross-domain handshake is required here.

Test Plan:
- All tests use Addr_Width=8 and Almost_Full_Thresh=4.
- Reset: wr_rstn=0 with wr_en=1 -> every output 0, mem_wr_en=0; after release, the first push gives wr_addr=0, mem_wr_en=1, and wr_ptr=9'h001 on the next cycle.
- Fill: rd_ptr_sync=0, wr_en=1 for 256 cycles -> almost_full rises after push 252 (wr_level=252); full=1 and wr_level=256 after push 256; wr_ptr=9'h180.
- Overflow: while full, wr_en=1 for 3 cycles -> mem_wr_en=0, wr_ptr held at 9'h180, overflow=1 and held; pulse ovf_clr -> overflow=0 next cycle; ovf_clr together with wr_en while full -> overflow stays 1.
- Drain release: with full=1, set rd_ptr_sync=9'h001 (Gray of 1) -> next cycle full=0, wr_level=255, almost_full=1; next push re-asserts full with wr_addr=0.
- Wrap: track rd_ptr_sync = Gray(wr_bin-10) over 600 pushes -> wr_level constant at 10, full never asserts, wr_bin wraps 511 -> 0, and wr_ptr changes exactly one bit per accepted push.
- Async reset mid-fill: assert wr_rstn low between clock edges at level 100 -> outputs clear before the next wr_clk edge; wr_ptr=0, full=0, wr_level=0.
